data_memory_arbiter: RTL and testbench
======================================

DATA_MEMORY_ARBITER -- requirements
Module: data_memory_arbiter

Interface
REQ-001 Parameter MEM_BYTES, 64, data memory size in bytes; legal doubleword addresses are 0..MEM_BYTES-8.
REQ-002 Parameter CNT_W, 16, width of the saturating conflict counter.
REQ-003 Port clock  input  1  sole clock; all state updates on its rising edge.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Ports p0_valid, p1_valid  input  1 each  request valid (p0 = pipeline MEM stage, p1 = loader/debug).
REQ-006 Ports p0_ready, p1_ready  output  1 each  request accepted this cycle.
REQ-007 Ports p0_we, p1_we  input  1 each  1 = doubleword write, 0 = doubleword read.
REQ-008 Ports p0_addr, p1_addr  input  64 each  byte address.
REQ-009 Ports p0_wdata, p1_wdata  input  64 each  write data, little-endian byte order.
REQ-010 Port resp_valid  output  1  response available.
REQ-011 Port resp_ready  input  1  response consumed.
REQ-012 Port resp_id  output  1  port that owns the response.
REQ-013 Port resp_rdata  output  64  read data; 0 for writes and errors.
REQ-014 Port resp_err  output  1  address out of range.
REQ-015 Ports mem_address, mem_write_data  output  64 each  to the data memory address/write-data inputs.
REQ-016 Ports mem_write, mem_read  output  1 each  to the data memory write/read enables.
REQ-017 Port mem_read_data  input  64  from the data memory read-data output (combinational read).
REQ-018 Port conflict_count  output  CNT_W  cycles in which a valid request was refused.

Function
REQ-019 The FSM SHALL have states IDLE, ACCESS and RESP.
REQ-020 In IDLE, exactly one of p0_ready/p1_ready SHALL be 1, chosen for the winning valid port; both SHALL be 0 when no port is valid and in all other states.
REQ-021 On valid&ready at edge T, the block SHALL latch we/addr/wdata/id and enter ACCESS.
REQ-022 In ACCESS, registered mem_address/mem_write_data SHALL hold the latched values; mem_write=we and mem_read=!we, both 0 if out of range.
REQ-023 Writes SHALL commit at the edge ending ACCESS; reads SHALL capture mem_read_data into resp_rdata at that edge; the FSM SHALL then enter RESP.
REQ-024 In RESP, resp_valid=1 with stable id/rdata/err until resp_ready=1; that edge SHALL return the FSM to IDLE.
REQ-025 Minimum latency SHALL be: accept at T, resp_valid at T+2, next accept at T+3.
REQ-026 The request SHALL be out of range when addr > MEM_BYTES-8; it SHALL give resp_err=1, resp_rdata=0 and perform no memory access.
REQ-027 Outside ACCESS, mem_write and mem_read SHALL be 0.
REQ-028 conflict_count SHALL increment by 1 per cycle in which any port has valid=1 and ready=0, and SHALL saturate at all-ones.
REQ-029 A port's request SHALL be ignored if it drops valid before acceptance; there is no requirement that valid be held.

Reset
REQ-030 At a reset edge, the block SHALL set state=IDLE, all ready/resp_* and mem_* outputs to 0, conflict_count=0 and last_grant=1.
REQ-031 Reset asserted during ACCESS SHALL NOT block the write sampled at that same edge; the response SHALL be discarded.
REQ-032 Reset asserted during RESP SHALL drop the pending response without a handshake.

Configuration
REQ-033 With DMEM_ARB_ROUND_ROBIN_EN defined, simultaneous valid requests SHALL be granted to the port that is not last_grant, and last_grant SHALL update on every accept.
REQ-034 Without the macro, port 0 SHALL always win simultaneous valid requests; last_grant SHALL still be tracked but SHALL not be used.

Structure
REQ-035 The state enum (IDLE/ACCESS/RESP) and the MEM_BYTES default SHALL live in the shared package dmem_arb_pkg.
REQ-036 Grant selection SHALL be a sub-module, dmem_arb_grant (inputs: p0_valid, p1_valid, last_grant; output: one-hot grant).

Verification
REQ-037 Bench SHALL cover: reset; p0 write addr=8 data=0x1122334455667788; p0 read addr=8 -> resp_rdata=0x1122334455667788, resp_id=0, err=0, resp_valid at T+2.
REQ-038 Bench SHALL cover: p1 read addr=57 -> resp_err=1, rdata=0, mem_read never 1; read addr=56 -> err=0.
REQ-039 Bench SHALL cover: p0 and p1 valid continuously with round-robin -> grants alternate 0,1,0,1; without the macro -> all grants to p0, conflict_count rises by 1 per IDLE cycle.
REQ-040 Bench SHALL cover: resp_ready held 0 for 5 cycles -> resp_* stable, no new accept; release -> IDLE next cycle.
REQ-041 Bench SHALL cover: reset asserted in RESP -> resp_valid=0 next cycle, state IDLE, conflict_count=0.
REQ-042 Bench SHALL cover: conflict_count preset near saturation (CNT_W=4, 20 refused cycles) -> holds 15.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the two-port data memory arbiter.
package dmem_arb_pkg;

  localparam int unsigned MEM_BYTES_DEFAULT = 64;
  localparam int unsigned XLEN              = 64;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_e;

  // One doubleword request as seen after the grant mux
  typedef struct packed {
    logic            id;
    logic            we;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
  } arb_req_t;

endpackage

// File: rtl/dmem_arb_grant.sv
// Two-port grant selection; DMEM_ARB_ROUND_ROBIN_EN enables round-robin on ties,
// otherwise port 0 has fixed priority.
module dmem_arb_grant (
  input  logic       p0_valid,
  input  logic       p1_valid,
  input  logic       last_grant,
  output logic [1:0] grant
);

`ifndef DMEM_ARB_ROUND_ROBIN_EN
  // last_grant is tracked by the top in every build but only consumed here with round-robin
  logic unused_last_grant;
  assign unused_last_grant = last_grant;
`endif

  always_comb begin
    grant = 2'b00;
    if (p0_valid && p1_valid) begin
`ifdef DMEM_ARB_ROUND_ROBIN_EN
      grant = last_grant ? 2'b01 : 2'b10;
`else
      grant = 2'b01;
`endif
    end else if (p0_valid) begin
      grant = 2'b01;
    end else if (p1_valid) begin
      grant = 2'b10;
    end
  end

endmodule

// File: rtl/data_memory_arbiter.sv
// Arbitrates the MEM stage (p0) and loader/debug (p1) onto one data memory port.
// Tie-break policy selected by DMEM_ARB_ROUND_ROBIN_EN (see dmem_arb_grant).
module data_memory_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned MEM_BYTES = MEM_BYTES_DEFAULT,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             p0_valid,
  output logic             p0_ready,
  input  logic             p0_we,
  input  logic [XLEN-1:0]  p0_addr,
  input  logic [XLEN-1:0]  p0_wdata,
  input  logic             p1_valid,
  output logic             p1_ready,
  input  logic             p1_we,
  input  logic [XLEN-1:0]  p1_addr,
  input  logic [XLEN-1:0]  p1_wdata,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_id,
  output logic [XLEN-1:0]  resp_rdata,
  output logic             resp_err,
  output logic [XLEN-1:0]  mem_address,
  output logic [XLEN-1:0]  mem_write_data,
  output logic             mem_write,
  output logic             mem_read,
  input  logic [XLEN-1:0]  mem_read_data,
  output logic [CNT_W-1:0] conflict_count
);

  localparam logic [XLEN-1:0] MAX_ADDR = XLEN'(MEM_BYTES - 8);

  arb_state_e state, state_nxt;
  arb_req_t   req_in;
  logic [1:0] grant;
  logic       last_grant;
  logic       id_q;
  logic       err_q;
  logic       accept;
  logic       in_range;
  logic       refused;

  dmem_arb_grant u_grant (
    .p0_valid   (p0_valid),
    .p1_valid   (p1_valid),
    .last_grant (last_grant),
    .grant      (grant)
  );

  // Next state and ready handshake; ready is only offered while idle
  always_comb begin
    state_nxt = state;
    p0_ready  = 1'b0;
    p1_ready  = 1'b0;
    case (state)
      IDLE: begin
        p0_ready = grant[0];
        p1_ready = grant[1];
        if (|grant) state_nxt = ACCESS;
      end
      ACCESS:  state_nxt = RESP;
      RESP:    if (resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request mux driven by the grant
  always_comb begin
    req_in.id    = grant[1];
    req_in.we    = grant[1] ? p1_we    : p0_we;
    req_in.addr  = grant[1] ? p1_addr  : p0_addr;
    req_in.wdata = grant[1] ? p1_wdata : p0_wdata;
  end

  assign accept   = (state == IDLE) && (|grant);
  assign in_range = (req_in.addr <= MAX_ADDR);
  assign refused  = (p0_valid && !p0_ready) || (p1_valid && !p1_ready);

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      last_grant     <= 1'b1;
      id_q           <= 1'b0;
      err_q          <= 1'b0;
      mem_address    <= '0;
      mem_write_data <= '0;
      mem_write      <= 1'b0;
      mem_read       <= 1'b0;
      resp_valid     <= 1'b0;
      resp_id        <= 1'b0;
      resp_rdata     <= '0;
      resp_err       <= 1'b0;
      conflict_count <= '0;
    end else begin
      state     <= state_nxt;
      mem_write <= 1'b0;
      mem_read  <= 1'b0;

      if (refused && (conflict_count != '1)) conflict_count <= conflict_count + CNT_W'(1);

      // Memory strobes are only raised for the single ACCESS cycle of a legal request
      if (accept) begin
        last_grant     <= req_in.id;
        id_q           <= req_in.id;
        err_q          <= !in_range;
        mem_address    <= req_in.addr;
        mem_write_data <= req_in.wdata;
        mem_write      <= req_in.we && in_range;
        mem_read       <= !req_in.we && in_range;
      end

      if (state == ACCESS) begin
        resp_valid <= 1'b1;
        resp_id    <= id_q;
        resp_err   <= err_q;
        resp_rdata <= mem_read ? mem_read_data : '0;
      end

      if ((state == RESP) && resp_ready) begin
        resp_valid <= 1'b0;
        resp_id    <= 1'b0;
        resp_err   <= 1'b0;
        resp_rdata <= '0;
      end
    end
  end

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Scoreboard bench for data_memory_arbiter: directed scenarios followed by random traffic.
`timescale 1ns/1ps
module tb_data_memory_arbiter;

  localparam int unsigned MEM_BYTES = 64;
  localparam int unsigned CNT_W     = 4;
  localparam logic [63:0] LAST_OK   = 64'(MEM_BYTES - 8);
`ifdef DMEM_ARB_ROUND_ROBIN_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  logic clock, reset;
  logic p0_valid, p0_ready, p0_we, p1_valid, p1_ready, p1_we;
  logic [63:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
  logic resp_valid, resp_ready, resp_id, resp_err;
  logic [63:0] resp_rdata, mem_address, mem_write_data, mem_read_data;
  logic mem_write, mem_read;
  logic [CNT_W-1:0] conflict_count;

  data_memory_arbiter #(.MEM_BYTES(MEM_BYTES), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset),
    .p0_valid(p0_valid), .p0_ready(p0_ready), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p1_valid(p1_valid), .p1_ready(p1_ready), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_write(mem_write), .mem_read(mem_read), .mem_read_data(mem_read_data),
    .conflict_count(conflict_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Environment memory: combinational read, write on the rising edge
  logic [7:0] env_mem [MEM_BYTES] = '{default: 8'h00};
  always_comb begin
    mem_read_data = '0;
    if (mem_address <= LAST_OK)
      for (int i = 0; i < 8; i++) mem_read_data[8*i +: 8] = env_mem[6'(mem_address[5:0] + 6'(i))];
  end
  always @(posedge clock)
    if (mem_write && mem_address <= LAST_OK)
      for (int i = 0; i < 8; i++) env_mem[6'(mem_address[5:0] + 6'(i))] <= mem_write_data[8*i +: 8];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference model state
  typedef struct {
    bit          id;
    bit          err;
    logic [63:0] rdata;
    int          first_cyc;
    bit          shown;
  } exp_t;
  exp_t q[$];

  logic [7:0]  ref_mem [MEM_BYTES] = '{default: 8'h00};
  bit          m_known = 0, m_busy = 0, m_last = 1, flush_pending = 0;
  int          m_acc_cyc = 0;
  int unsigned m_cnt = 0;
  bit          m_we, m_err;
  logic [63:0] m_addr, m_wdata;

  function automatic logic [1:0] pick(input logic v0, input logic v1, input bit last);
    if (v0 && v1) return RR_EN ? (last ? 2'b01 : 2'b10) : 2'b01;
    return {v1, v0};
  endfunction

  function automatic logic [63:0] ref_read(input logic [63:0] a);
    logic [63:0] d;
    d = '0;
    for (int i = 0; i < 8; i++) d[8*i +: 8] = ref_mem[6'(a[5:0] + 6'(i))];
    return d;
  endfunction

  // Model: check this cycle's outputs, then predict the effect of the coming edge
  initial begin
    logic [1:0] g;
    bit in_acc, refused, id;
    forever begin
      @(negedge clock);
      if (flush_pending) begin q.delete(); flush_pending = 0; end
      g = m_busy ? 2'b00 : pick(p0_valid, p1_valid, m_last);
      in_acc = m_busy && (cyc == m_acc_cyc);
      if (m_known) begin
        chk("ready", 64'({p1_ready, p0_ready}), 64'(g));
        chk("conflict_count", 64'(conflict_count), 64'(m_cnt));
        chk("resp_valid", 64'(resp_valid), 64'(m_busy && cyc > m_acc_cyc));
        chk("mem_write", 64'(mem_write), 64'(in_acc && m_we && !m_err));
        chk("mem_read", 64'(mem_read), 64'(in_acc && !m_we && !m_err));
        if (in_acc && !m_err) chk("mem_address", mem_address, m_addr);
        if (in_acc && !m_err && m_we) chk("mem_write_data", mem_write_data, m_wdata);
      end
      if (reset) begin
        m_busy = 0; m_last = 1; m_cnt = 0; flush_pending = 1; m_known = 1;
      end else begin
        refused = (p0_valid && !g[0]) || (p1_valid && !g[1]);
        if (refused && m_cnt < (2**CNT_W) - 1) m_cnt++;
        if (g != 2'b00) begin
          id      = g[1];
          m_we    = id ? p1_we : p0_we;
          m_addr  = id ? p1_addr : p0_addr;
          m_wdata = id ? p1_wdata : p0_wdata;
          m_err   = m_addr > LAST_OK;
          q.push_back('{id: id, err: m_err,
                        rdata: (!m_err && !m_we) ? ref_read(m_addr) : 64'h0,
                        first_cyc: cyc + 2, shown: 0});
          if (!m_err && m_we)
            for (int i = 0; i < 8; i++) ref_mem[6'(m_addr[5:0] + 6'(i))] = m_wdata[8*i +: 8];
          m_busy = 1; m_acc_cyc = cyc + 1; m_last = id;
        end else if (m_busy && cyc > m_acc_cyc && resp_ready) begin
          m_busy = 0;
        end
      end
    end
  end

  // Monitor: compare every presented response against the scoreboard head
  initial begin
    forever begin
      @(negedge clock); #1;
      if (resp_valid === 1'b1) begin
        if (q.size() == 0) begin
          chk("resp_unexpected", 64'(resp_valid), 64'h0);
        end else begin
          chk("resp_id", 64'(resp_id), 64'(q[0].id));
          chk("resp_err", 64'(resp_err), 64'(q[0].err));
          chk("resp_rdata", resp_rdata, q[0].rdata);
          if (!q[0].shown) begin
            chk("resp_latency_cycle", 64'(cyc), 64'(q[0].first_cyc));
            q[0].shown = 1;
          end
          if (resp_ready) void'(q.pop_front());
        end
      end
    end
  end

  task automatic issue(input bit port, input bit we, input logic [63:0] addr, input logic [63:0] data);
    int t;
    @(posedge clock); #1;
    if (port) begin p1_valid = 1; p1_we = we; p1_addr = addr; p1_wdata = data; end
    else      begin p0_valid = 1; p0_we = we; p0_addr = addr; p0_wdata = data; end
    t = 0;
    do begin @(negedge clock); t++; end while (!(port ? p1_ready : p0_ready) && t < 40);
    if (t >= 40) chk("issue_timeout", 64'(t), 64'h0);
    @(posedge clock); #1;
    if (port) p1_valid = 0; else p0_valid = 0;
  endtask

  task automatic pulse_reset();
    @(posedge clock); #1 reset = 1;
    @(posedge clock); #1 reset = 0;
  endtask

  initial begin
    int grants[$];
    int t;
    reset = 1; resp_ready = 1;
    p0_valid = 0; p0_we = 0; p0_addr = '0; p0_wdata = '0;
    p1_valid = 0; p1_we = 0; p1_addr = '0; p1_wdata = '0;
    repeat (3) @(posedge clock);
    #1 reset = 0;
    @(negedge clock);
    chk("reset_resp_valid", 64'(resp_valid), 64'h0);
    chk("reset_conflict", 64'(conflict_count), 64'h0);
    chk("reset_mem_strobes", 64'({mem_write, mem_read}), 64'h0);

    // Write/read back at address 8, then range boundary on p1
    issue(0, 1, 64'd8, 64'h1122334455667788);
    issue(0, 0, 64'd8, 64'h0);
    issue(1, 0, 64'd57, 64'h0);
    issue(1, 1, 64'd56, 64'hA5A5_0F0F_1234_5678);
    issue(1, 0, 64'd56, 64'h0);
    repeat (3) @(posedge clock);

    // Response back-pressure with a competing request pending
    resp_ready = 0;
    issue(1, 0, 64'd8, 64'h0);
    #0 p0_valid = 1; p0_we = 0; p0_addr = 64'd16;
    repeat (6) @(posedge clock);
    #1 resp_ready = 1;
    repeat (2) @(posedge clock);
    #1 p0_valid = 0;
    repeat (4) @(posedge clock);

    // Continuous contention from both ports after a fresh reset
    pulse_reset();
    @(posedge clock); #1;
    p0_valid = 1; p0_we = 0; p0_addr = 64'd0;
    p1_valid = 1; p1_we = 0; p1_addr = 64'd16;
    repeat (24) begin
      @(negedge clock);
      if (p0_ready) grants.push_back(0);
      if (p1_ready) grants.push_back(1);
    end
    chk("grant_count", 64'(grants.size()), 64'd8);
    foreach (grants[i]) chk("grant_order", 64'(grants[i]), RR_EN ? 64'(i % 2) : 64'h0);
    chk("conflict_saturated", 64'(conflict_count), 64'd15);
    @(posedge clock); #1 p0_valid = 0; p1_valid = 0;
    repeat (4) @(posedge clock);

    // Reset while a response is stalled
    resp_ready = 0;
    issue(0, 0, 64'd8, 64'h0);
    t = 0;
    do begin @(negedge clock); t++; end while (resp_valid !== 1'b1 && t < 20);
    chk("resp_seen_before_reset", 64'(resp_valid), 64'h1);
    pulse_reset();
    @(negedge clock);
    chk("rst_resp_drop", 64'(resp_valid), 64'h0);
    chk("rst_conflict", 64'(conflict_count), 64'h0);
    resp_ready = 1;

    // Reset during ACCESS must not lose the write
    issue(0, 1, 64'd24, 64'hDEAD_BEEF_CAFE_F00D);
    reset = 1;
    @(posedge clock); #1 reset = 0;
    issue(0, 0, 64'd24, 64'h0);
    repeat (3) @(posedge clock);

    // Random traffic
    repeat (200) begin
      @(posedge clock); #1;
      p0_valid = 1'($urandom_range(0, 1));
      p1_valid = 1'($urandom_range(0, 1));
      p0_we = 1'($urandom_range(0, 1));
      p1_we = 1'($urandom_range(0, 1));
      for (int p = 0; p < 2; p++) begin
        logic [63:0] a;
        case ($urandom_range(0, 9))
          7:       a = 64'($urandom_range(0, 63));
          8:       a = 64'($urandom_range(57, 63));
          9:       a = {32'hFFFF_FFFF, 32'($urandom)};
          default: a = 64'(8 * $urandom_range(0, 7));
        endcase
        if (p == 0) begin p0_addr = a; p0_wdata = {32'($urandom), 32'($urandom)}; end
        else        begin p1_addr = a; p1_wdata = {32'($urandom), 32'($urandom)}; end
      end
      resp_ready = ($urandom_range(0, 3) != 0);
    end
    @(posedge clock); #1;
    p0_valid = 0; p1_valid = 0; resp_ready = 1;
    repeat (8) @(posedge clock);
    @(negedge clock); #2;
    chk("scoreboard_drained", 64'(q.size()), 64'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

endmodule
